// File: rtl/uart_sched_pkg.sv
// Shared types and width helpers for the UART transmit scheduler.
// Defaults match the console/debug configuration used by the SoC.
package uart_sched_pkg;

   localparam int DEF_N_REQ        = 4;
   localparam int DEF_IDLE_TIMEOUT = 1024;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // A zero timeout still needs a 1-bit counter so the declaration stays legal.
   function automatic int cnt_w(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin pick: first set request at or above the pointer, wrapping modulo N_REQ.
// Searches a doubled request vector whose lower half is masked below the pointer.
module rr_pick
   import uart_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_grant,
   output logic             o_any
);

   logic [2*N_REQ-1:0] w_dbl;

   assign w_dbl = {i_req, i_req};
   assign o_any = |i_req;

   always_comb begin
      // NOTE: the output gets a default before the search so no path leaves it unassigned (no latch).
      o_grant = '0;
      // Descending scan so the lowest unmasked bit wins.
      for (int i = 2*N_REQ-1; i >= 0; i--) begin
         if (w_dbl[i] && (i >= int'(i_ptr))) begin
            o_grant = IDX_W'(i % N_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter among N_REQ requesters, one whole message per grant,
// with round-robin fairness and a stall timeout that reclaims an abandoned grant.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter  int N_REQ        = DEF_N_REQ,
   parameter  int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   localparam int OWNER_W      = idx_w(N_REQ)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic [OWNER_W-1:0]   owner,
   output logic                 timeout_pulse
);

   localparam int               CNT_W   = cnt_w(IDLE_TIMEOUT);
   localparam bit               TO_EN   = (IDLE_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(IDLE_TIMEOUT - 1) : '0;

   state_t             r_state;
   logic [OWNER_W-1:0] r_owner;
   logic [OWNER_W-1:0] r_rr_ptr;
   logic [CNT_W-1:0]   r_idle_cnt;
   logic               r_timeout_pulse;

   logic [OWNER_W-1:0] w_pick;
   logic               w_any;
   logic               w_owner_valid;
   logic               w_owner_last;
   logic               w_accept;
   logic               w_expire;
   logic [OWNER_W-1:0] w_next_ptr;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (OWNER_W)
   ) u_pick (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   assign w_owner_valid = req_valid[r_owner];
   assign w_owner_last  = req_last[r_owner];

   // Datapath is decoded from state so an async reset drops the grant without a clock.
   assign busy          = (r_state == GRANT);
   assign owner         = r_owner;
   assign timeout_pulse = r_timeout_pulse;
   assign tx_data       = req_data[8*r_owner +: 8];
   assign tx_valid      = busy && w_owner_valid;
   assign w_accept      = tx_valid && tx_ready;
   assign w_expire      = TO_EN && busy && !w_owner_valid && (r_idle_cnt == TO_LAST);
   assign w_next_ptr    = (r_owner == OWNER_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

   always_comb begin
      req_ready = '0;
      if (busy) begin
         req_ready[r_owner] = tx_ready;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= IDLE;
         r_owner         <= '0;
         r_rr_ptr        <= '0;
         r_idle_cnt      <= '0;
         r_timeout_pulse <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         r_timeout_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner    <= w_pick;
                  r_idle_cnt <= '0;
                  r_state    <= GRANT;
               end
            end
            GRANT: begin
               if (w_accept) begin
                  r_idle_cnt <= '0;
                  if (w_owner_last) begin
                     r_state  <= IDLE;
                     r_rr_ptr <= w_next_ptr;
                  end
               end else if (w_owner_valid) begin
                  // Transmitter back-pressure is not a stall by the owner.
                  r_idle_cnt <= '0;
               end else if (w_expire) begin
                  r_state         <= IDLE;
                  r_rr_ptr        <= w_next_ptr;
                  r_idle_cnt      <= '0;
                  r_timeout_pulse <= 1'b1;
               end else if (r_idle_cnt != CNT_MAX) begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: per-requester byte sources, a transmitter ready model,
// and a scoreboard of {owner, last, data} in the expected order on the tx side.
module tb_uart_tx_scheduler;

   localparam int N  = 4;
   localparam int TO = 8;
   localparam int OW = 2;
   localparam logic [N-1:0] ONE = 1;

   logic            clk      = 1'b0;
   logic            reset_n  = 1'b0;
   logic [8*N-1:0]  req_data = 32'h3C965AA5;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_last  = '0;
   logic [N-1:0]    req_ready;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready = 1'b0;
   logic            busy;
   logic [OW-1:0]   owner;
   logic            timeout_pulse;

   uart_tx_scheduler #(
      .N_REQ        (N),
      .IDLE_TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .busy          (busy),
      .owner         (owner),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [8:0]  src_mem [N][32];
   int          src_head [N];
   int          src_tail [N];
   logic [10:0] sb [$];
   logic [N-1:0] acc_mask = '0;
   int          tx_period = 0;
   int          tx_phase  = 0;
   logic        tx_level  = 1'b0;
   int          pulse_cnt = 0;
   int          pulse_cyc = -1;
   int          acc_cnt   = 0;
   int          acc_cyc   = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // Requester and transmitter models, driven just after the active edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_mask[i] && (src_head[i] < src_tail[i])) src_head[i]++;
         if (src_head[i] < src_tail[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = src_mem[i][src_head[i] % 32][7:0];
            req_last[i]        = src_mem[i][src_head[i] % 32][8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      acc_mask = '0;
      if (tx_period > 0) begin
         tx_ready = (tx_phase == 0);
         tx_phase = (tx_phase + 1 >= tx_period) ? 0 : tx_phase + 1;
      end else begin
         tx_ready = tx_level;
      end
   end

   // Monitor: samples on the falling edge, pops the scoreboard on every accept.
   always @(negedge clk) begin
      logic [10:0] exp_v;
      if (reset_n) begin
         acc_mask = req_ready & req_valid;
         if (timeout_pulse) begin
            pulse_cnt++;
            pulse_cyc = cyc;
         end
         if (tx_valid && tx_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_accept: owner=%0d data=%02h, expected no accept", owner, tx_data);
            end else begin
               exp_v = sb.pop_front();
               if ({owner, req_last[owner], tx_data} !== exp_v)begin
                  n_err++;
                  $display("FAIL tx_byte: got owner=%0d last=%0b data=%02h, expected owner=%0d last=%0b data=%02h",
                           owner, req_last[owner], tx_data, exp_v[10:9], exp_v[8], exp_v[7:0]);
               end
            end
            n_cmp++;
            if (req_ready !== (ONE << owner)) begin
               n_err++;
               $display("FAIL ready_onehot: got req_ready=%b, expected %b", req_ready, ONE << owner);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input int idx, input logic [7:0] d, input logic last);
      src_mem[idx][src_tail[idx] % 32] = {last, d};
      src_tail[idx]++;
   endtask

   task automatic expect_byte(input int idx, input logic [7:0] d, input logic last);
      sb.push_back({OW'(idx), last, d});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_head[i] = 0;
         src_tail[i] = 0;
      end
      sb.delete();
      acc_mask  = '0;
      tx_period = 0;
      tx_phase  = 0;
      tx_level  = 1'b0;
      pulse_cnt = 0;
      pulse_cyc = -1;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic drain(input int budget);
      int k;
      for (k = 0; k < budget && (sb.size() != 0 || busy || req_valid != '0); k++) tick();
      n_cmp++;
      if (sb.size() != 0 || busy || req_valid != '0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d bytes pending busy=%0b after %0d cycles, expected 0 pending",
                  sb.size(), busy, budget);
      end
   endtask

   task automatic wait_accept(input int budget, output int c);
      int k;
      int start;
      start = acc_cnt;
      for (k = 0; k < budget && acc_cnt == start; k++) tick();
      n_cmp++;
      if (acc_cnt == start) begin
         n_err++;
         $display("FAIL accept_timeout: got no accept in %0d cycles, expected one", budget);
      end
      c = acc_cyc;
   endtask

   task automatic wait_cyc(input int target);
      int k;
      for (k = 0; k < 200 && cyc < target; k++) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      n_cmp++;
      if ({busy, tx_valid, req_ready, timeout_pulse} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%0b tx_valid=%0b req_ready=%b pulse=%0b, expected all 0",
                  busy, tx_valid, req_ready, timeout_pulse);
      end
      n_cmp++;
      if (owner !== '0) begin
         n_err++;
         $display("FAIL reset_owner: got %0d, expected 0", owner);
      end
      n_cmp++;
      if (tx_data !== 8'hA5) begin
         n_err++;
         $display("FAIL reset_tx_data: got %02h, expected a5", tx_data);
      end
      do_reset();
      repeat (3) tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_no_request: got busy=%0b, expected 0", busy);
      end
   endtask

   task automatic test_single_message();
      int k;
      int bad;
      int acc0;
      do_reset();
      tx_period = 1085;
      push(1, 8'h41, 1'b0); expect_byte(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b0); expect_byte(1, 8'h42, 1'b0);
      push(1, 8'h43, 1'b1); expect_byte(1, 8'h43, 1'b1);
      acc0 = acc_cnt;
      bad  = 0;
      tick();
      for (k = 0; k < 6000 && sb.size() != 0; k++) begin
         tick();
         if (!busy || owner !== 2'd1) bad++;
      end
      n_cmp++;
      if (bad != 0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL single_owner: got %0d cycles off owner 1 and %0d bytes pending, expected 0 and 0", bad, sb.size());
      end
      n_cmp++;
      if (acc_cnt - acc0 != 3) begin
         n_err++;
         $display("FAIL single_accepts: got %0d, expected 3", acc_cnt - acc0);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || owner !== 2'd1) begin
         n_err++;
         $display("FAIL single_release: got busy=%0b owner=%0d, expected busy=0 owner=1", busy, owner);
      end
      // Round-robin pointer now sits at 2: requester 2 beats requester 0.
      tx_period = 0;
      tx_level  = 1'b1;
      push(0, 8'h10, 1'b1);
      push(2, 8'h20, 1'b1);
      expect_byte(2, 8'h20, 1'b1);
      expect_byte(0, 8'h10, 1'b1);
      drain(100);
   endtask

   task automatic test_contention();
      do_reset();
      tx_period = 3;
      push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
      push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
      push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
      expect_byte(0, 8'hA0, 1'b0); expect_byte(0, 8'hA1, 1'b1);
      expect_byte(2, 8'hC0, 1'b0); expect_byte(2, 8'hC1, 1'b1);
      expect_byte(3, 8'hD0, 1'b0); expect_byte(3, 8'hD1, 1'b1);
      expect_byte(0, 8'hA2, 1'b0); expect_byte(0, 8'hA3, 1'b1);
      drain(500);
   endtask

   task automatic test_wrap();
      do_reset();
      tx_level = 1'b1;
      push(2, 8'h22, 1'b1); expect_byte(2, 8'h22, 1'b1);
      drain(50);
      push(3, 8'h33, 1'b1);
      push(0, 8'h30, 1'b1);
      expect_byte(3, 8'h33, 1'b1);
      expect_byte(0, 8'h30, 1'b1);
      drain(50);
      push(0, 8'h31, 1'b1);
      push(1, 8'h11, 1'b1);
      expect_byte(1, 8'h11, 1'b1);
      expect_byte(0, 8'h31, 1'b1);
      drain(50);
      // Pointer is 1 after requester 0; a lone requester 0 must still be granted.
      push(0, 8'h0E, 1'b1); expect_byte(0, 8'h0E, 1'b1);
      drain(50);
      push(0, 8'h0F, 1'b1); expect_byte(0, 8'h0F, 1'b1);
      drain(50);
   endtask

   task automatic test_stall_timeout();
      int c;
      do_reset();
      tx_level = 1'b1;
      push(2, 8'h55, 1'b0); expect_byte(2, 8'h55, 1'b0);
      wait_accept(50, c);
      push(3, 8'h66, 1'b1); expect_byte(3, 8'h66, 1'b1);
      wait_cyc(c + 9);
      n_cmp++;
      if (timeout_pulse !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL stall_expire: got pulse=%0b busy=%0b, expected pulse=1 busy=0", timeout_pulse, busy);
      end
      n_cmp++;
      if (pulse_cnt != 1 || pulse_cyc != c + 9) begin
         n_err++;
         $display("FAIL stall_pulse_time: got %0d pulses, last %0d cycles after drop, expected 1 pulse at 8",
                  pulse_cnt, pulse_cyc - c - 1);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b1 || owner !== 2'd3 || timeout_pulse !== 1'b0) begin
         n_err++;
         $display("FAIL stall_regrant: got busy=%0b owner=%0d pulse=%0b, expected busy=1 owner=3 pulse=0",
                  busy, owner, timeout_pulse);
      end
      drain(50);
      n_cmp++;
      if (pulse_cnt != 1) begin
         n_err++;
         $display("FAIL stall_pulse_count: got %0d, expected 1", pulse_cnt);
      end
   endtask

   task automatic test_collision();
      int c;
      do_reset();
      tx_level = 1'b1;
      push(1, 8'h71, 1'b0); expect_byte(1, 8'h71, 1'b0);
      wait_accept(50, c);
      wait_cyc(c + 7);
      push(1, 8'h72, 1'b1); expect_byte(1, 8'h72, 1'b1);
      tick();
      tick();
      n_cmp++;
      if (acc_cyc != c + 8 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
         n_err++;
         $display("FAIL collision_release: got accept at +%0d busy=%0b pulse=%0b, expected accept at +8 busy=0 pulse=0",
                  acc_cyc - c, busy, timeout_pulse);
      end
      repeat (12) tick();
      n_cmp++;
      if (pulse_cnt != 0) begin
         n_err++;
         $display("FAIL collision_pulse: got %0d pulses, expected 0", pulse_cnt);
      end
      drain(20);
   endtask

   task automatic test_async_reset();
      int c;
      do_reset();
      tx_level = 1'b1;
      push(0, 8'h81, 1'b0); expect_byte(0, 8'h81, 1'b0);
      push(0, 8'h82, 1'b0); expect_byte(0, 8'h82, 1'b0);
      push(0, 8'h83, 1'b1); expect_byte(0, 8'h83, 1'b1);
      wait_accept(50, c);
      tick();
      n_cmp++;
      if (tx_valid !== 1'b1 || req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL pre_reset_grant: got tx_valid=%0b req_ready=%b, expected 1 and 0001", tx_valid, req_ready);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, tx_valid, req_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL async_reset_drop: got busy=%0b tx_valid=%0b req_ready=%b, expected all 0",
                  busy, tx_valid, req_ready);
      end
      do_reset();
      tx_level = 1'b1;
      push(3, 8'h93, 1'b1);
      push(0, 8'h90, 1'b1);
      expect_byte(0, 8'h90, 1'b1);
      expect_byte(3, 8'h93, 1'b1);
      drain(50);
   endtask

   initial begin
      test_reset();
      test_single_message();
      test_contention();
      test_wrap();
      test_stall_timeout();
      test_collision();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter (byte-wide valid/ready input, 8N1 serialiser) among N_REQ byte-stream requesters.
- Round-robin arbitration, granted once per message: once a requester is granted, its bytes go out back-to-back until it accepts a byte flagged last, so messages never interleave on the serial line.
- A stall timeout releases the grant if the owner stops supplying bytes mid-message.
- Sits between the CPU-side mem-mapped UART port, debug/console sources and the transmitter.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- IDLE_TIMEOUT, 1024, cycles the owner may hold the grant with req_valid low before forced release; 0 disables the timeout.
- OWNER_W, $clog2(N_REQ), width of the owner index (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_data  in  8*N_REQ  byte from each requester; requester i on bits [8i+7:8i].
- req_valid  in  N_REQ  requester i has a byte.
- req_last  in  N_REQ  byte on requester i ends its message.
- req_ready  out  N_REQ  byte from requester i accepted this cycle.
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  to the transmitter's data_in_valid.
- tx_ready  in  1  from the transmitter's data_in_ready.
- busy  out  1  a grant is held (state GRANT).
- owner  out  OWNER_W  current or most recent grantee.
- timeout_pulse  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, owner=0, rr_ptr=0, idle_cnt=0.
  - Outputs: busy=0, tx_valid=0, req_ready=0, timeout_pulse=0, tx_data=req_data[0].
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr, modulo N_REQ.
  - Register it as owner, clear idle_cnt, go to GRANT.
  - No byte is passed in IDLE; first-byte latency is 1 cycle from req_valid to tx_valid.
- GRANT datapath (combinational):
  - tx_data = req_data[owner].
  - tx_valid = req_valid[owner].
  - req_ready[owner] = tx_ready; all other req_ready bits are 0.
- Accept: a cycle with tx_valid && tx_ready.
  - Accept with req_last[owner]=1: go to IDLE, rr_ptr = owner+1 (wraps N_REQ-1 -> 0).
  - Accept with req_last[owner]=0: stay in GRANT, clear idle_cnt.
- Stall counter:
  - Cycles in GRANT with req_valid[owner]=0 increment idle_cnt; any cycle with req_valid[owner]=1 clears it.
  - When IDLE_TIMEOUT>0 and idle_cnt==IDLE_TIMEOUT-1 with valid still low: go to IDLE, rr_ptr=owner+1, timeout_pulse=1 for one cycle.
  - idle_cnt width is $clog2(IDLE_TIMEOUT+1); it saturates and never wraps.
- Transmitter-busy stalls (valid high, tx_ready low) never count toward the timeout.
- IDLE->GRANT always costs one cycle, so back-to-back messages have a one-cycle arbitration gap.
  - This gap is hidden behind the 10-bit symbol time because the transmitter is still busy.
- A sole requester is re-granted even though rr_ptr skipped past it.
- owner holds its value in IDLE; outputs are decoded from state, not registered separately.
- Reset mid-message: the grant is dropped immediately. A byte already accepted by the transmitter completes there; it is not the scheduler's concern.
- Protocol rule: req_data and req_last are stable while req_valid is high and unaccepted. The scheduler does not check this.

Decomposition:
- Package uart_sched_pkg holds:
  - state enum {IDLE, GRANT};
  - function clog2-based width helpers;
  - default N_REQ/IDLE_TIMEOUT constants.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index and any_req.
  - Implemented as a double-width masked priority search.
- The FSM, counter and output mux stay in uart_tx_scheduler.

Test Plan:
- Single message: req 1 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_ready pulsed once per 1085 cycles -> exactly 3 accepts in order, owner=1 throughout, busy drops the cycle after the last accept, rr_ptr=2.
- Contention: reqs 0,2,3 all valid, 2-byte messages each -> grant order 0,2,3,0; no interleaving; req_ready only ever set on owner.
- Wrap: rr_ptr=3, reqs 3 and 0 valid -> 3 granted first, then 0; rr_ptr wraps to 0 then 1.
- Stall timeout, IDLE_TIMEOUT=8: owner 2 sends 1 non-last byte then drops valid -> timeout_pulse exactly 8 cycles after valid drops, state IDLE, waiting req 3 granted next cycle.
- Collision: last byte accepted in the same cycle the counter would expire -> normal release, timeout_pulse stays 0.
- Async reset: assert reset_n mid-message -> busy, tx_valid and req_ready go to 0 without a clock edge; after release, req 0 with rr_ptr=0 is granted first.
